// File: rtl/load_pkg.sv
// Shared types and constants for the data-memory load unit.
// Provides the FSM state enum, word geometry and the default abort timeout.
package load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int WORD_BYTES  = 4;
    localparam int LANE_W      = $clog2(WORD_BYTES);
    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/load_align.sv
// Byte-lane extraction and extension of a memory read word.
// Ports: mem_rdata/lane/byte_sel/sign_ext in, data out (aligned result).
module load_align
    import load_pkg::*;
(
    input  logic [31:0]       mem_rdata,
    input  logic [LANE_W-1:0] lane,
    input  logic              byte_sel,
    input  logic              sign_ext,
    output logic [31:0]       data
);

    logic [7:0] lane_byte;

    always_comb begin
        lane_byte = mem_rdata[8*lane +: 8];
        if (byte_sel) begin
            data = {{24{sign_ext & lane_byte[7]}}, lane_byte};
        end else begin
            data = mem_rdata;
        end
    end

endmodule

// File: rtl/load_unit.sv
// Load engine: one word-aligned memory read per command, then byte/word extract.
// Ports: clk, rst, start/addr/byte_sel/sign_ext in; busy/done/err/rd_data out;
// mem_req/mem_addr out, mem_rdata/mem_valid in. Option: LOAD_UNIT_TIMEOUT_EN.
module load_unit
    import load_pkg::*;
#(
    parameter int N       = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] addr,
    input  logic         byte_sel,
    input  logic         sign_ext,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] rd_data,
    output logic         mem_req,
    output logic [N-1:0] mem_addr,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_valid
);

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic [N-1:0]      mem_addr_q, mem_addr_d;
    logic [N-1:0]      rd_data_q, rd_data_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              byte_sel_q, byte_sel_d;
    logic              sign_ext_q, sign_ext_d;
    logic [N-1:0]      aligned;

`ifdef LOAD_UNIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    load_align u_align (
        .mem_rdata (mem_rdata),
        .lane      (lane_q),
        .byte_sel  (byte_sel_q),
        .sign_ext  (sign_ext_q),
        .data      (aligned)
    );

    always_comb begin
        state_d    = state_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        lane_d     = lane_q;
        byte_sel_d = byte_sel_q;
        sign_ext_d = sign_ext_q;
`ifdef LOAD_UNIT_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {addr[N-1:2], 2'b00};
                    lane_d     = addr[LANE_W-1:0];
                    byte_sel_d = byte_sel;
                    sign_ext_d = sign_ext;
`ifdef LOAD_UNIT_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            REQ, WAIT: begin
                if (mem_valid) begin
                    state_d   = DONE;
                    rd_data_d = aligned;
                    done_d    = 1'b1;
`ifdef LOAD_UNIT_TIMEOUT_EN
                // cnt_q counts completed REQ/WAIT cycles, so this is the last
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    rd_data_d = '0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    state_d   = WAIT;
                    mem_req_d = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
`else
                end else begin
                    state_d   = WAIT;
                    mem_req_d = 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rd_data_q  <= '0;
            lane_q     <= '0;
            byte_sel_q <= 1'b0;
            sign_ext_q <= 1'b0;
`ifdef LOAD_UNIT_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rd_data_q  <= rd_data_d;
            lane_q     <= lane_d;
            byte_sel_q <= byte_sel_d;
            sign_ext_q <= sign_ext_d;
`ifdef LOAD_UNIT_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rd_data  = rd_data_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: word/byte loads, wait states, reset, timeout.
// Ports: none; drives the DUT with TIMEOUT=4 and checks with assertions.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] addr;
    logic        byte_sel;
    logic        sign_ext;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rd_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] WORD = 32'hE1A0_20A2;

    load_unit #(.N(32), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .addr      (addr),
        .byte_sel  (byte_sel),
        .sign_ext  (sign_ext),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_data   (rd_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue a load answered in REQ, check request, result and pulse timing.
    task automatic zero_wait(input string tag, input logic [31:0] a,
                             input logic bs, input logic se,
                             input logic [31:0] exp);
        start    = 1'b1;
        addr     = a;
        byte_sel = bs;
        sign_ext = se;
        tick();
        start = 1'b0;
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
        mem_valid = 1'b1;
        mem_rdata = WORD;
        tick();
        mem_valid = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_data"}, rd_data, exp);
        chk({tag, "_reqlow"}, {31'd0, mem_req}, 32'd0);
        tick();
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, rd_data, exp);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        addr      = 32'h0000_0010;
        byte_sel  = 1'b0;
        sign_ext  = 1'b0;
        mem_rdata = 32'h0;
        mem_valid = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk("rst_nostart", {31'd0, busy}, 32'd0);

        zero_wait("word", 32'h0000_0104, 1'b0, 1'b0, 32'hE1A0_20A2);
        zero_wait("word_un", 32'h0000_0107, 1'b0, 1'b1, 32'hE1A0_20A2);
        zero_wait("b3s", 32'h0020_0003, 1'b1, 1'b1, 32'hFFFF_FFE1);
        zero_wait("b1z", 32'h0020_0001, 1'b1, 1'b0, 32'h0000_0020);
        zero_wait("b0s", 32'h0020_0000, 1'b1, 1'b1, 32'hFFFF_FFA2);
        zero_wait("b2s", 32'h0020_0002, 1'b1, 1'b1, 32'hFFFF_FFA0);
        zero_wait("b3z", 32'h0020_0003, 1'b1, 1'b0, 32'h0000_00E1);

        // wait states: valid arrives in cycle k+4, done in k+5
        start    = 1'b1;
        addr     = 32'h0000_0208;
        byte_sel = 1'b0;
        tick();
        start = 1'b0;
        chk("ws_req1", {31'd0, mem_req}, 32'd1);
        tick();
        start = 1'b1;
        addr  = 32'h0000_0300;
        chk("ws_req2", {31'd0, mem_req}, 32'd1);
        chk("ws_addr2", mem_addr, 32'h0000_0208);
        tick();
        start = 1'b0;
        chk("ws_req3", {31'd0, mem_req}, 32'd1);
        chk("ws_addr3", mem_addr, 32'h0000_0208);
        chk("ws_nodone3", {31'd0, done}, 32'd0);
        tick();
        chk("ws_req4", {31'd0, mem_req}, 32'd1);
        chk("ws_nodone4", {31'd0, done}, 32'd0);
        mem_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_valid = 1'b0;
        chk("ws_done", {31'd0, done}, 32'd1);
        chk("ws_data", rd_data, 32'h1234_5678);
        tick();
        chk("ws_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("ws_ignored", {31'd0, busy}, 32'd0);
        chk("ws_ignreq", {31'd0, mem_req}, 32'd0);

        // reset in WAIT abandons the load
        start    = 1'b1;
        addr     = 32'h0000_0400;
        tick();
        start = 1'b0;
        tick();
        chk("rm_wait", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_req", {31'd0, mem_req}, 32'd0);
        chk("rm_busy", {31'd0, busy}, 32'd0);
        chk("rm_data", rd_data, 32'd0);
        mem_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        chk("rm_nodone1", {31'd0, done}, 32'd0);
        tick();
        mem_valid = 1'b0;
        chk("rm_nodone2", {31'd0, done}, 32'd0);
        chk("rm_data2", rd_data, 32'd0);

        // no valid: with timeout, abort after 4 REQ/WAIT cycles
        zero_wait("pre_to", 32'h0000_0500, 1'b0, 1'b0, 32'hE1A0_20A2);
        start = 1'b1;
        addr  = 32'h0000_0600;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("to_k4_done", {31'd0, done}, 32'd0);
        chk("to_k4_req", {31'd0, mem_req}, 32'd1);
        tick();
`ifdef LOAD_UNIT_TIMEOUT_EN
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_data", rd_data, 32'd0);
        tick();
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_errpulse", {31'd0, err}, 32'd0);
        // valid on the final counted cycle wins over the abort
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        mem_valid = 1'b1;
        mem_rdata = 32'h0BAD_CAFE;
        tick();
        mem_valid = 1'b0;
        chk("vw_done", {31'd0, done}, 32'd1);
        chk("vw_err", {31'd0, err}, 32'd0);
        chk("vw_data", rd_data, 32'h0BAD_CAFE);
        tick();
`else
        for (int i = 0; i < 16; i++) tick();
        chk("nto_busy", {31'd0, busy}, 32'd1);
        chk("nto_req", {31'd0, mem_req}, 32'd1);
        chk("nto_err", {31'd0, err}, 32'd0);
        chk("nto_done", {31'd0, done}, 32'd0);
        mem_valid = 1'b1;
        mem_rdata = 32'h0BAD_CAFE;
        tick();
        mem_valid = 1'b0;
        chk("nto_fin", {31'd0, done}, 32'd1);
        chk("nto_ferr", {31'd0, err}, 32'd0);
        chk("nto_data", rd_data, 32'h0BAD_CAFE);
        tick();
`endif
        chk("end_idle", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
